// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared types and defaults for the VGA frame-buffer reader.
//   fb_state_e      - reader FSM states (also driven out on state_dbg)
//   DEF_*           - default buffer bases and frame/burst/FIFO geometry
package vga_fb_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SPACE = 2'd1,
    REQ        = 2'd2,
    DATA       = 2'd3
  } fb_state_e;

  localparam logic [31:0] DEF_FB0_BASE    = 32'h0000_0000;
  localparam logic [31:0] DEF_FB1_BASE    = 32'h0020_0000;
  localparam int          DEF_FRAME_WORDS = 153600;  // 640x480, 2 px/word
  localparam int          DEF_BURST_LEN   = 8;
  localparam int          DEF_FIFO_DEPTH  = 256;

endpackage

// File: rtl/vga_fb_reader.sv
// vga_fb_reader: Avalon-MM burst-read master streaming the front frame buffer
// from SDRAM into the VGA pixel FIFO, with double-buffer swap at frame end.
//
// Ports
//   clk_clk, reset_reset_n   clock, async active-low reset
//   enable, pll_locked       streaming allowed while both are high
//   swap_req / swap_ack      swap request pulse / pulse when the swap lands
//   front_sel                buffer being scanned (0 = FB0, 1 = FB1)
//   frame_start              pulse in the cycle word 0 of a frame is accepted
//   overflow                 sticky: a beat arrived while fifo_full was high
//   avm_*                    Avalon-MM burst read master
//   fifo_full, fifo_usedw    pixel FIFO status
//   fifo_wr_en, exportdata   pixel FIFO write port (one cycle after each beat)
//   state_dbg                current FSM state
//
// Handshake: avm_read and avm_address are held stable from the first REQ
// cycle until a cycle with avm_waitrequest low, which is the accept cycle.
// Each avm_readdatavalid beat is data; exactly BURST_LEN beats follow an
// accept and only one burst is ever outstanding.
module vga_fb_reader
  import vga_fb_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] FB0_BASE    = ADDR_W'(DEF_FB0_BASE),
  parameter logic [ADDR_W-1:0] FB1_BASE    = ADDR_W'(DEF_FB1_BASE),
  parameter int                FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int                BURST_LEN   = DEF_BURST_LEN,
  parameter int                FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int                USEDW_W     = 8
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset_n,
  input  logic                        enable,
  input  logic                        pll_locked,
  input  logic                        swap_req,
  output logic                        swap_ack,
  output logic                        front_sel,
  output logic                        frame_start,
  output logic                        overflow,
  output logic [ADDR_W-1:0]           avm_address,
  output logic                        avm_read,
  output logic [$clog2(BURST_LEN):0]  avm_burstcount,
  input  logic                        avm_waitrequest,
  input  logic [31:0]                 avm_readdata,
  input  logic                        avm_readdatavalid,
  input  logic                        fifo_full,
  input  logic [USEDW_W-1:0]          fifo_usedw,
  output logic                        fifo_wr_en,
  output logic [31:0]                 exportdata,
  output logic [1:0]                  state_dbg
);

  localparam int BC_W     = $clog2(BURST_LEN) + 1;
  localparam int WORD_W   = $clog2(FRAME_WORDS + 1);
  localparam int BEAT_W   = $clog2(BURST_LEN + 1);
  // Largest fill level that still leaves room for a whole burst.
  localparam int HEADROOM = FIFO_DEPTH - 1 - BURST_LEN;

  localparam logic [WORD_W-1:0] BURST_STEP     = WORD_W'(BURST_LEN);
  localparam logic [WORD_W-1:0] LAST_BURST_IDX = WORD_W'(FRAME_WORDS - BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT      = BEAT_W'(BURST_LEN - 1);

  fb_state_e          state;
  logic [WORD_W-1:0]  word_idx;
  logic [BEAT_W-1:0]  beat_cnt;
  logic               swap_pending;

  logic               run_ok;
  logic               space_ok;
  logic [ADDR_W-1:0]  burst_addr;

  assign run_ok     = enable && pll_locked;
  assign space_ok   = !fifo_full && (32'(fifo_usedw) <= 32'(HEADROOM));
  assign burst_addr = (front_sel ? FB1_BASE : FB0_BASE) + ADDR_W'({word_idx, 2'b00});

  assign avm_burstcount = BC_W'(BURST_LEN);
  assign state_dbg      = state;

  // Decoded from the live accept condition so it marks the accept cycle
  // itself, which may come after several waitrequest stalls.
  assign frame_start = (state == REQ) && avm_read && !avm_waitrequest &&
                       (word_idx == '0);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state        <= IDLE;
      word_idx     <= '0;
      beat_cnt     <= '0;
      swap_pending <= 1'b0;
      front_sel    <= 1'b0;
      swap_ack     <= 1'b0;
      overflow     <= 1'b0;
      avm_read     <= 1'b0;
      avm_address  <= '0;
      fifo_wr_en   <= 1'b0;
      exportdata   <= '0;
    end else begin
      swap_ack   <= 1'b0;
      fifo_wr_en <= 1'b0;
      if (swap_req) swap_pending <= 1'b1;

      case (state)
        IDLE: begin
          // A fresh start always begins at word 0 of the current front buffer.
          if (run_ok) begin
            word_idx <= '0;
            state    <= WAIT_SPACE;
          end
        end

        WAIT_SPACE: begin
          if (!run_ok) begin
            state <= IDLE;
          end else if (space_ok) begin
            avm_read    <= 1'b1;
            avm_address <= burst_addr;
            state       <= REQ;
          end
        end

        REQ: begin
          // Avalon does not allow withdrawing a request, so enable/lock
          // loss is ignored until the burst has drained.
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            beat_cnt <= '0;
            state    <= DATA;
          end
        end

        DATA: begin
          if (avm_readdatavalid) begin
            // The write is issued even when full; the FIFO drops it.
            fifo_wr_en <= 1'b1;
            exportdata <= avm_readdata;
            if (fifo_full) overflow <= 1'b1;

            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              if (word_idx == LAST_BURST_IDX) begin
                word_idx <= '0;
                if (swap_pending) begin
                  front_sel    <= ~front_sel;
                  swap_ack     <= 1'b1;
                  // A request landing on the swap cycle waits for next frame.
                  swap_pending <= swap_req;
                end
              end else begin
                word_idx <= word_idx + BURST_STEP;
              end
              state <= run_ok ? WAIT_SPACE : IDLE;
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fb_reader.sv
module tb_vga_fb_reader;

  localparam int BURST_LEN   = 8;
  localparam int FRAME_WORDS = 64;

  // ---------------- clock / reset ----------------
  logic clk_clk       = 1'b0;
  logic reset_reset_n = 1'b1;
  always #5 clk_clk = ~clk_clk;

  logic        enable            = 1'b0;
  logic        pll_locked        = 1'b0;
  logic        swap_req          = 1'b0;
  logic        swap_ack;
  logic        front_sel;
  logic        frame_start;
  logic        overflow;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_burstcount;
  logic        avm_waitrequest   = 1'b0;
  logic [31:0] avm_readdata      = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        fifo_full         = 1'b0;
  logic [7:0]  fifo_usedw        = '0;
  logic        fifo_wr_en;
  logic [31:0] exportdata;
  logic [1:0]  state_dbg;

  vga_fb_reader #(
    .FRAME_WORDS (FRAME_WORDS),
    .BURST_LEN   (BURST_LEN)
  ) dut (
    .clk_clk           (clk_clk),
    .reset_reset_n     (reset_reset_n),
    .enable            (enable),
    .pll_locked        (pll_locked),
    .swap_req          (swap_req),
    .swap_ack          (swap_ack),
    .front_sel         (front_sel),
    .frame_start       (frame_start),
    .overflow          (overflow),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_burstcount    (avm_burstcount),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .fifo_full         (fifo_full),
    .fifo_usedw        (fifo_usedw),
    .fifo_wr_en        (fifo_wr_en),
    .exportdata        (exportdata),
    .state_dbg         (state_dbg)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- scoreboard + SDRAM slave model ----------------
  logic [31:0] exp_q[$];
  int          wr_count        = 0;
  int          bursts_accepted = 0;
  int          wait_cfg        = 0;
  bit          in_req, accept_now, prev_beat;
  int          wait_left, beats_left, beat_i;
  logic [31:0] acc_addr, cur_addr, exp_word;

  initial begin : slave_model
    forever begin
      @(negedge clk_clk);
      if (!reset_reset_n) begin
        in_req = 0; accept_now = 0; prev_beat = 0;
        wait_left = 0; beats_left = 0; beat_i = 0;
        avm_readdatavalid = 1'b0;
        avm_waitrequest   = 1'b0;
        exp_q.delete();
        wr_count = 0;
        bursts_accepted = 0;
      end else begin
        // FIFO write must follow each beat by exactly one cycle.
        checks++;
        if (fifo_wr_en !== prev_beat) begin
          failures++;
          $display("FAIL wr_timing: fifo_wr_en=%b expected %b at %0t", fifo_wr_en, prev_beat, $time);
        end else if (fifo_wr_en) begin
          wr_count++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL wr_data: write of %h with no beat outstanding", exportdata);
          end else begin
            exp_word = exp_q.pop_front();
            if (exportdata !== exp_word) begin
              failures++;
              $display("FAIL wr_data: exportdata=%h expected %h", exportdata, exp_word);
            end
          end
        end

        avm_readdatavalid = 1'b0;
        if (accept_now) begin
          accept_now = 0;
          cur_addr   = acc_addr;
          beats_left = BURST_LEN;
          beat_i     = 0;
          bursts_accepted++;
        end
        if (beats_left > 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = {8'hD0 + 8'(beat_i), cur_addr[23:0]};
          exp_q.push_back(avm_readdata);
          beat_i++;
          beats_left--;
        end
        prev_beat = avm_readdatavalid;

        if (avm_read && !in_req) begin
          in_req    = 1;
          wait_left = wait_cfg;
        end
        if (in_req) begin
          if (wait_left > 0) begin
            avm_waitrequest = 1'b1;
            wait_left--;
          end else begin
            avm_waitrequest = 1'b0;
            accept_now      = 1;
            acc_addr        = avm_address;
            in_req          = 0;
          end
        end else begin
          avm_waitrequest = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk_clk);
    #1;
  endtask

  task automatic do_reset();
    enable = 0; pll_locked = 0; swap_req = 0;
    fifo_full = 0; fifo_usedw = '0; wait_cfg = 0;
    tick();
    reset_reset_n = 1'b0;
    repeat (3) tick();
    reset_reset_n = 1'b1;
    tick();
  endtask

  // Returns in the accept cycle (avm_read high, waitrequest low).
  task automatic wait_accept(output logic [31:0] addr, output logic fs, output bit ok);
    ok = 0; addr = '0; fs = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (avm_read && !avm_waitrequest) begin
        addr = avm_address;
        fs   = frame_start;
        ok   = 1;
        break;
      end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL accept_timeout: no accepted read within 200 cycles");
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tick();
    reset_reset_n = 1'b0;
    repeat (2) tick();
    checks++;
    if ({avm_read, avm_address, fifo_wr_en, exportdata, front_sel, swap_ack, frame_start, overflow} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: read=%b addr=%h wr=%b data=%h fs=%b ack=%b fstart=%b ovf=%b expected all 0",
               avm_read, avm_address, fifo_wr_en, exportdata, front_sel, swap_ack, frame_start, overflow);
    end
    checks++;
    if (state_dbg !== 2'd0) begin
      failures++; $display("FAIL reset_state: state=%0d expected 0", state_dbg);
    end
    reset_reset_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (state_dbg !== 2'd0 || avm_read !== 1'b0) begin
      failures++; $display("FAIL idle_disabled: state=%0d read=%b expected 0/0", state_dbg, avm_read);
    end
  endtask

  task automatic test_first_bursts();
    logic [31:0] a; logic fs; bit ok;
    do_reset();
    enable = 1; pll_locked = 1;
    wait_accept(a, fs, ok);
    if (ok) begin
      checks++;
      if (a !== 32'h0) begin failures++; $display("FAIL first_addr: %h expected 00000000", a); end
      checks++;
      if (avm_burstcount !== 4'd8) begin failures++; $display("FAIL burstcount: %0d expected 8", avm_burstcount); end
      checks++;
      if (fs !== 1'b1) begin failures++; $display("FAIL first_frame_start: %b expected 1", fs); end
    end
    wait_accept(a, fs, ok);
    if (ok) begin
      checks++;
      if (a !== 32'h20) begin failures++; $display("FAIL second_addr: %h expected 00000020", a); end
      checks++;
      if (fs !== 1'b0) begin failures++; $display("FAIL second_frame_start: %b expected 0", fs); end
    end
    enable = 0;
    repeat (15) tick();
    checks++;
    if (wr_count !== 16 || exp_q.size() !== 0) begin
      failures++; $display("FAIL first_writes: writes=%0d left=%0d expected 16/0", wr_count, exp_q.size());
    end
    checks++;
    if (overflow !== 1'b0 || avm_read !== 1'b0) begin
      failures++; $display("FAIL first_quiet: ovf=%b read=%b expected 0/0", overflow, avm_read);
    end
  endtask

  task automatic test_headroom();
    bit seen = 0;
    bit got  = 0;
    do_reset();
    fifo_usedw = 8'd248;
    enable = 1; pll_locked = 1;
    repeat (10) begin
      tick();
      if (avm_read) seen = 1;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL headroom_248: read=1 expected 0"); end
    checks++;
    if (state_dbg !== 2'd1) begin failures++; $display("FAIL headroom_state: %0d expected 1", state_dbg); end
    fifo_usedw = 8'd247;
    repeat (2) begin
      tick();
      if (avm_read) got = 1;
    end
    checks++;
    if (!got) begin failures++; $display("FAIL headroom_247: read=0 expected 1 within 2 cycles"); end
    enable = 0;
    fifo_usedw = '0;
    repeat (15) tick();
    checks++;
    if (wr_count !== 8) begin failures++; $display("FAIL headroom_writes: %0d expected 8", wr_count); end
  endtask

  task automatic test_waitrequest();
    logic [31:0] addr0;
    int  n      = 0;
    bit  stable = 1;
    bit  found  = 0;
    do_reset();
    wait_cfg = 5;
    enable = 1; pll_locked = 1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (avm_read) begin found = 1; break; end
    end
    enable = 0;
    checks++;
    if (!found) begin
      failures++; $display("FAIL wait_req_seen: no avm_read within 50 cycles");
    end else begin
      addr0 = avm_address;
      while (avm_read && n < 20) begin
        if (avm_address !== addr0) stable = 0;
        n++;
        tick();
      end
      checks++;
      if (n !== 6 || !stable || addr0 !== 32'h0) begin
        failures++; $display("FAIL wait_hold: cycles=%0d stable=%b addr=%h expected 6/1/00000000", n, stable, addr0);
      end
    end
    repeat (15) tick();
    checks++;
    if (bursts_accepted !== 1 || wr_count !== 8) begin
      failures++; $display("FAIL wait_single: bursts=%0d writes=%0d expected 1/8", bursts_accepted, wr_count);
    end
    wait_cfg = 0;
  endtask

  task automatic test_swap();
    logic [31:0] a; logic fs; bit ok;
    bit found = 0;
    do_reset();
    enable = 1; pll_locked = 1;
    wait_accept(a, fs, ok);
    wait_accept(a, fs, ok);
    checks++;
    if (front_sel !== 1'b0) begin failures++; $display("FAIL pre_swap_sel: %b expected 0", front_sel); end
    swap_req = 1;
    tick();
    swap_req = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (swap_ack) begin found = 1; break; end
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL swap_ack_timeout: no swap_ack within 300 cycles");
    end else begin
      checks++;
      if (front_sel !== 1'b1 || wr_count !== 64) begin
        failures++; $display("FAIL swap_point: front_sel=%b writes=%0d expected 1/64", front_sel, wr_count);
      end
      wait_accept(a, fs, ok);
      if (ok) begin
        checks++;
        if (a !== 32'h0020_0000 || fs !== 1'b1) begin
          failures++; $display("FAIL swap_next_addr: addr=%h fstart=%b expected 00200000/1", a, fs);
        end
        checks++;
        if (swap_ack !== 1'b0) begin failures++; $display("FAIL swap_ack_pulse: %b expected 0", swap_ack); end
      end
    end
    enable = 0;
    repeat (15) tick();
  endtask

  task automatic test_pll_drop();
    logic [31:0] a; logic fs; bit ok;
    bit quiet = 1;
    do_reset();
    enable = 1; pll_locked = 1;
    wait_accept(a, fs, ok);
    wait_accept(a, fs, ok);
    tick();
    pll_locked = 0;
    repeat (15) begin
      tick();
      if (avm_read) quiet = 0;
    end
    checks++;
    if (!quiet || wr_count !== 16 || state_dbg !== 2'd0) begin
      failures++; $display("FAIL pll_drain: quiet=%b writes=%0d state=%0d expected 1/16/0", quiet, wr_count, state_dbg);
    end
    pll_locked = 1;
    wait_accept(a, fs, ok);
    if (ok) begin
      checks++;
      if (a !== 32'h0 || fs !== 1'b1) begin
        failures++; $display("FAIL pll_restart: addr=%h fstart=%b expected 00000000/1", a, fs);
      end
    end
    enable = 0;
    repeat (15) tick();
  endtask

  task automatic test_overflow();
    logic [31:0] a; logic fs; bit ok;
    do_reset();
    enable = 1; pll_locked = 1;
    wait_accept(a, fs, ok);
    tick();
    fifo_full = 1;
    tick();
    fifo_full = 0;
    enable = 0;
    repeat (15) tick();
    checks++;
    if (overflow !== 1'b1 || wr_count !== 8) begin
      failures++; $display("FAIL overflow_set: ovf=%b writes=%0d expected 1/8", overflow, wr_count);
    end
    repeat (20) tick();
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_sticky: %b expected 1", overflow); end
    tick();
    reset_reset_n = 1'b0;
    tick();
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL overflow_clear: %b expected 0", overflow); end
    reset_reset_n = 1'b1;
    tick();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    #1;
    reset_reset_n = 1'b0;
    test_reset();
    test_first_bursts();
    test_headroom();
    test_waitrequest();
    test_swap();
    test_pll_drop();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
